// File: rtl/symbol_decoder.sv
// symbol_decoder: multi-cycle signed argmax over a captured score vector, LANES compares per beat.
module symbol_decoder #(
    parameter int QN          = 6,
    parameter int QM          = 11,
    parameter int NUM_SYMBOLS = 8,
    parameter int LANES       = 2
) (
    input  logic                                     clock,
    input  logic                                     reset,
    input  logic                                     newSample_in,
    input  logic [NUM_SYMBOLS*(QN+QM+1)-1:0]         inputVec,
    output logic                                     newSample_out,
    output logic [((NUM_SYMBOLS > 2) ? $clog2(NUM_SYMBOLS) : 1)-1:0] symbolOut,
    output logic [QN+QM:0]                           maxScore,
    output logic                                     busy,
    output logic                                     dropped
);
    localparam int BITWIDTH     = QN + QM + 1;
    localparam int SYM_BITWIDTH = (NUM_SYMBOLS > 2) ? $clog2(NUM_SYMBOLS) : 1;
    localparam int SCAN_CYCLES  = NUM_SYMBOLS / LANES;
    localparam int BEAT_W       = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam logic [BITWIDTH-1:0] MOST_NEG = {1'b1, {(BITWIDTH-1){1'b0}}};

    typedef enum logic {IDLE, SCAN} stateType;

    stateType                          state, nextState;
    logic [NUM_SYMBOLS*BITWIDTH-1:0]   vecReg;
    logic [BEAT_W-1:0]                 beat;
    logic signed [BITWIDTH-1:0]        bestScore, chainScore, elem;
    logic [SYM_BITWIDTH-1:0]           bestIdx, chainIdx;
    logic                              lastBeat;

    assign lastBeat = beat == BEAT_W'(SCAN_CYCLES - 1);
    assign busy     = state != IDLE;

    always_comb begin
        nextState = state == IDLE ? (newSample_in ? SCAN : IDLE) : (lastBeat ? IDLE : SCAN);
    end

    // Lanes chain in ascending index order; strict compare keeps the lowest index on ties.
    always_comb begin
        chainScore = bestScore;
        chainIdx   = bestIdx;
        elem       = '0;
        for (int j = 0; j < LANES; j++) begin
            elem = $signed(vecReg[(int'(beat) * LANES + j) * BITWIDTH +: BITWIDTH]);
            if (elem > chainScore) begin
                chainScore = elem;
                chainIdx   = SYM_BITWIDTH'(int'(beat) * LANES + j);
            end
        end
    end

    always_ff @(posedge clock) begin
        state <= !reset ? IDLE : nextState;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            vecReg        <= '0;
            beat          <= '0;
            bestScore     <= '0;
            bestIdx       <= '0;
            symbolOut     <= '0;
            maxScore      <= '0;
            newSample_out <= 1'b0;
            dropped       <= 1'b0;
        end else begin
            newSample_out <= state == SCAN && lastBeat;
            dropped       <= state == SCAN && newSample_in;
            if (state == IDLE && newSample_in) begin
                vecReg    <= inputVec;
                bestScore <= MOST_NEG;
                bestIdx   <= '0;
                beat      <= '0;
            end else if (state == SCAN) begin
                bestScore <= chainScore;
                bestIdx   <= chainIdx;
                beat      <= lastBeat ? '0 : beat + 1'b1;
                if (lastBeat) begin
                    symbolOut <= chainIdx;
                    maxScore  <= chainScore;
                end
            end
        end
    end
endmodule
